// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC register, next-PC selection with redirect priority,
// IF/ID pipeline register, and a sticky halt on any illegal fetch address.
module fetch_unit #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INST  = 32'h0000_0000,
    parameter int unsigned ROM_BYTES = 128
) (
    input  logic        Clk,
    input  logic        Clrn,
    input  logic        Stall,
    input  logic        BranchTaken,
    input  logic [31:0] BranchTarget,
    input  logic        Jump,
    input  logic [31:0] JumpTarget,
    input  logic [31:0] Inst,
    output logic [31:0] Addr,
    output logic [31:0] IF_ID_Inst,
    output logic [31:0] IF_ID_PC4,
    output logic        IF_ID_Valid,
    output logic        Fault,
    output logic [31:0] FetchCount
);

    localparam logic [31:0] ROM_LIMIT = 32'(ROM_BYTES);

    typedef enum logic {
        RUN,
        HALT
    } state_t;

    state_t      state;
    logic [31:0] pc_plus4;
    logic [31:0] next_pc;
    logic        redirect;
    logic        illegal;

    always_comb begin
        pc_plus4 = Addr + 32'd4;
        redirect = BranchTaken | Jump;
        if (BranchTaken)
            next_pc = BranchTarget;
        else if (Jump)
            next_pc = JumpTarget;
        else
            next_pc = pc_plus4;
        illegal = (next_pc[1:0] != 2'b00) || (next_pc >= ROM_LIMIT);
    end

    always_ff @(posedge Clk or negedge Clrn) begin
        if (!Clrn) begin
            state       <= RUN;
            Addr        <= RESET_PC;
            IF_ID_Inst  <= NOP_INST;
            IF_ID_PC4   <= '0;
            IF_ID_Valid <= 1'b0;
            Fault       <= 1'b0;
            FetchCount  <= '0;
        end else begin
            unique case (state)
                RUN: begin
                    if (!Stall) begin
                        if (illegal) begin
                            // PC keeps the last legal address for the rest of HALT
                            IF_ID_Inst  <= NOP_INST;
                            IF_ID_PC4   <= '0;
                            IF_ID_Valid <= 1'b0;
                            Fault       <= 1'b1;
                            state       <= HALT;
                        end else if (redirect) begin
                            Addr        <= next_pc;
                            IF_ID_Inst  <= NOP_INST;
                            IF_ID_PC4   <= '0;
                            IF_ID_Valid <= 1'b0;
                        end else begin
                            Addr        <= next_pc;
                            IF_ID_Inst  <= Inst;
                            IF_ID_PC4   <= pc_plus4;
                            IF_ID_Valid <= 1'b1;
                            FetchCount  <= FetchCount + 32'd1;
                        end
                    end
                end
                HALT: begin
                    IF_ID_Inst  <= NOP_INST;
                    IF_ID_PC4   <= '0;
                    IF_ID_Valid <= 1'b0;
                end
                default: state <= HALT;
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: redirects, stalls, faults, halt and async reset.
module tb_fetch_unit;

    logic        Clk;
    logic        Clrn;
    logic        Stall;
    logic        BranchTaken;
    logic [31:0] BranchTarget;
    logic        Jump;
    logic [31:0] JumpTarget;
    logic [31:0] Inst;
    logic [31:0] Addr;
    logic [31:0] IF_ID_Inst;
    logic [31:0] IF_ID_PC4;
    logic        IF_ID_Valid;
    logic        Fault;
    logic [31:0] FetchCount;

    int unsigned checks = 0;
    int unsigned passes = 0;

    fetch_unit #(
        .RESET_PC (32'h0000_0000),
        .NOP_INST (32'h0000_0000),
        .ROM_BYTES(128)
    ) dut (
        .Clk         (Clk),
        .Clrn        (Clrn),
        .Stall       (Stall),
        .BranchTaken (BranchTaken),
        .BranchTarget(BranchTarget),
        .Jump        (Jump),
        .JumpTarget  (JumpTarget),
        .Inst        (Inst),
        .Addr        (Addr),
        .IF_ID_Inst  (IF_ID_Inst),
        .IF_ID_PC4   (IF_ID_PC4),
        .IF_ID_Valid (IF_ID_Valid),
        .Fault       (Fault),
        .FetchCount  (FetchCount)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // Instruction memory model: distinctive word per address
    function automatic logic [31:0] inst_at(input logic [31:0] a);
        if (a == 32'h0) return 32'h2001_0008;
        return 32'hC0DE_0000 | a;
    endfunction

    assign Inst = inst_at(Addr);

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic idle();
        Stall = 1'b0; BranchTaken = 1'b0; Jump = 1'b0;
        BranchTarget = '0; JumpTarget = '0;
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_addr"},  Addr,        32'h0);
        chk({tag, "_inst"},  IF_ID_Inst,  32'h0);
        chk({tag, "_pc4"},   IF_ID_PC4,   32'h0);
        chk({tag, "_valid"}, {31'b0, IF_ID_Valid}, 32'h0);
        chk({tag, "_fault"}, {31'b0, Fault},       32'h0);
        chk({tag, "_count"}, FetchCount,  32'h0);
    endtask

    task automatic pulse_reset(input string tag);
        idle();
        Clrn = 1'b0;
        #2;
        chk_reset(tag);
        Clrn = 1'b1;
    endtask

    initial begin
        idle();
        Clrn = 1'b0;
        #12;
        chk_reset("reset");
        Clrn = 1'b1;

        // first fetch from RESET_PC
        tick();
        chk("f1_addr",  Addr,       32'h4);
        chk("f1_inst",  IF_ID_Inst, 32'h2001_0008);
        chk("f1_pc4",   IF_ID_PC4,  32'h4);
        chk("f1_valid", {31'b0, IF_ID_Valid}, 32'h1);
        chk("f1_count", FetchCount, 32'h1);

        tick();
        chk("f2_addr",  Addr,       32'h8);
        chk("f2_inst",  IF_ID_Inst, 32'hC0DE_0004);
        chk("f2_count", FetchCount, 32'h2);

        // stall outranks branch for two cycles
        Stall = 1'b1; BranchTaken = 1'b1; BranchTarget = 32'h40;
        tick();
        tick();
        chk("stall_addr",  Addr,       32'h8);
        chk("stall_inst",  IF_ID_Inst, 32'hC0DE_0004);
        chk("stall_pc4",   IF_ID_PC4,  32'h8);
        chk("stall_valid", {31'b0, IF_ID_Valid}, 32'h1);
        chk("stall_count", FetchCount, 32'h2);

        Stall = 1'b0;
        tick();
        chk("br1_addr",  Addr,       32'h40);
        chk("br1_inst",  IF_ID_Inst, 32'h0);
        chk("br1_pc4",   IF_ID_PC4,  32'h0);
        chk("br1_valid", {31'b0, IF_ID_Valid}, 32'h0);
        chk("br1_count", FetchCount, 32'h2);

        idle();
        Jump = 1'b1; JumpTarget = 32'h10;
        tick();
        chk("jmp_addr",  Addr,       32'h10);
        chk("jmp_valid", {31'b0, IF_ID_Valid}, 32'h0);
        chk("jmp_count", FetchCount, 32'h2);

        idle();
        tick();
        tick();
        chk("seq_addr",  Addr,       32'h18);
        chk("seq_inst",  IF_ID_Inst, 32'hC0DE_0014);
        chk("seq_pc4",   IF_ID_PC4,  32'h18);
        chk("seq_count", FetchCount, 32'h4);

        // branch beats a simultaneous jump
        BranchTaken = 1'b1; BranchTarget = 32'h34;
        Jump = 1'b1; JumpTarget = 32'h20;
        tick();
        chk("br2_addr",  Addr,       32'h34);
        chk("br2_inst",  IF_ID_Inst, 32'h0);
        chk("br2_valid", {31'b0, IF_ID_Valid}, 32'h0);
        chk("br2_count", FetchCount, 32'h4);

        // illegal jump: halts with PC held
        idle();
        Jump = 1'b1; JumpTarget = 32'h82;
        tick();
        chk("jf_fault", {31'b0, Fault}, 32'h1);
        chk("jf_addr",  Addr,       32'h34);
        chk("jf_valid", {31'b0, IF_ID_Valid}, 32'h0);
        chk("jf_count", FetchCount, 32'h4);

        JumpTarget = 32'h10;
        tick();
        BranchTaken = 1'b1; BranchTarget = 32'h20;
        tick();
        Jump = 1'b0; BranchTaken = 1'b0;
        tick();
        chk("halt_addr",  Addr,       32'h34);
        chk("halt_fault", {31'b0, Fault}, 32'h1);
        chk("halt_valid", {31'b0, IF_ID_Valid}, 32'h0);
        chk("halt_count", FetchCount, 32'h4);

        pulse_reset("halt_rst");

        // misaligned but in-range branch target
        tick();
        BranchTaken = 1'b1; BranchTarget = 32'h12;
        tick();
        chk("mis_fault", {31'b0, Fault}, 32'h1);
        chk("mis_addr",  Addr,       32'h4);
        chk("mis_count", FetchCount, 32'h1);

        pulse_reset("mis_rst");

        // aligned target exactly at ROM_BYTES
        Jump = 1'b1; JumpTarget = 32'h80;
        tick();
        chk("oob_fault", {31'b0, Fault}, 32'h1);
        chk("oob_addr",  Addr,       32'h0);
        chk("oob_count", FetchCount, 32'h0);

        pulse_reset("oob_rst");

        // reset between edges mid-run
        tick();
        tick();
        tick();
        chk("pre_addr", Addr, 32'hC);
        pulse_reset("mid_rst");

        // sequential run to the end of the window
        for (int i = 0; i < 31; i++) tick();
        chk("end_addr",  Addr,       32'h7C);
        chk("end_inst",  IF_ID_Inst, 32'hC0DE_0078);
        chk("end_pc4",   IF_ID_PC4,  32'h7C);
        chk("end_count", FetchCount, 32'd31);
        chk("end_fault", {31'b0, Fault}, 32'h0);

        tick();
        chk("wrap_fault", {31'b0, Fault}, 32'h1);
        chk("wrap_addr",  Addr,       32'h7C);
        chk("wrap_valid", {31'b0, IF_ID_Valid}, 32'h0);
        chk("wrap_count", FetchCount, 32'd31);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
